// File: rtl/frame_plotter_pkg.sv
// Shared geometry, colour constants and FSM encoding for the bitmap-to-framebuffer plotter.
package frame_plotter_pkg;

  localparam int CELLS_X   = 16;
  localparam int CELLS_Y   = 32;
  localparam int NUM_CELLS = CELLS_X * CELLS_Y;
  localparam int CX_W      = $clog2(CELLS_X);
  localparam int CY_W      = $clog2(CELLS_Y);
  localparam int IDX_W     = $clog2(NUM_CELLS);

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;

  localparam logic [2:0] COLOUR_FG = 3'b000;
  localparam logic [2:0] COLOUR_BG = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/frame_plotter_cell_pixel_walker.sv
// Walks the SCALE x SCALE pixel block of one cell, sx fastest, and registers
// the screen address of the pixel currently being plotted.
module cell_pixel_walker
  import frame_plotter_pkg::*;
#(
  parameter int SCALE    = 3,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            advance,
  input  logic [CX_W-1:0] cx,
  input  logic [CY_W-1:0] cy,
  output logic [7:0]      x,
  output logic [6:0]      y,
  output logic            last
);

  localparam int CW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [CW-1:0] LAST_S = CW'(SCALE - 1);

  logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          step;

  assign last = (sx_q == LAST_S) && (sy_q == LAST_S);
  assign step = start || (advance && !last);

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (start) begin
      sx_d = '0;
      sy_d = '0;
    end else if (advance && !last) begin
      if (sx_q == LAST_S) begin
        sx_d = '0;
        sy_d = sy_q + CW'(1);
      end else begin
        sx_d = sx_q + CW'(1);
      end
    end
  end

  // Address arithmetic is deliberately held at the framebuffer widths.
  assign x_d = 8'(X_OFFSET) + 8'(cx) * 8'(SCALE) + 8'(sx_d);
  assign y_d = 7'(Y_OFFSET) + 7'(cy) * 7'(SCALE) + 7'(sy_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      sx_q <= '0;
      sy_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (step) begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/frame_plotter.sv
// Snapshots the cell bitmap on each frame tick and streams pixel writes for
// every cell that changed since the previous frame (or all cells on a redraw).
module frame_plotter
  import frame_plotter_pkg::*;
#(
  parameter int         SCALE     = 3,
  parameter int         X_OFFSET  = 0,
  parameter int         Y_OFFSET  = 0,
  parameter logic [2:0] FG_COLOUR = COLOUR_FG,
  parameter logic [2:0] BG_COLOUR = COLOUR_BG
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_CELLS-1:0] display,
  input  logic                 force_redraw,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  if ((X_OFFSET + CELLS_X * SCALE > SCREEN_W) ||
      (Y_OFFSET + CELLS_Y * SCALE > SCREEN_H)) begin : g_bad_geometry
    $error("frame_plotter: plot area does not fit the framebuffer");
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_CELLS-1:0] cur_q, cur_d, prev_q, prev_d;
  logic                 full_q, full_d, pending_q, pending_d;
  logic                 busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic                 plot_q, plot_d;
  logic [2:0]           colour_q, colour_d;
  logic                 cell_sel, idx_last, walk_start, walk_last;

  assign cell_sel   = full_q | (cur_q[idx_q] ^ prev_q[idx_q]);
  assign idx_last   = (idx_q == IDX_W'(NUM_CELLS - 1));
  assign walk_start = (state_q == ST_SCAN) && cell_sel;

  cell_pixel_walker #(
    .SCALE    (SCALE),
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET)
  ) u_walker (
    .clock   (clock),
    .reset   (reset),
    .start   (walk_start),
    .advance (state_q == ST_DRAW),
    .cx      (idx_q[IDX_W-1:CY_W]),
    .cy      (idx_q[CY_W-1:0]),
    .x       (x),
    .y       (y),
    .last    (walk_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cur_q     <= '0;
      prev_q    <= '0;
      full_q    <= 1'b0;
      pending_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      plot_q    <= 1'b0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      full_q    <= full_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      plot_q    <= plot_d;
      colour_q  <= colour_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_tick) state_d = ST_SCAN;
      ST_SCAN: begin
        if (cell_sel)      state_d = ST_DRAW;
        else if (idx_last) state_d = ST_FINISH;
      end
      ST_DRAW:   if (walk_last) state_d = idx_last ? ST_FINISH : ST_SCAN;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    full_d    = full_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          cur_d     = display;
          full_d    = force_redraw | pending_q;
          pending_d = 1'b0;
          idx_d     = '0;
          busy_d    = 1'b1;
        end
      end
      ST_SCAN:   if (!cell_sel && !idx_last) idx_d = idx_q + IDX_W'(1);
      ST_DRAW:   if (walk_last && !idx_last) idx_d = idx_q + IDX_W'(1);
      ST_FINISH: begin
        prev_d = cur_q;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    // A tick seen in FINISH still counts as overrun: busy is high until the edge that leaves it.
    overrun_d = overrun_q | (frame_tick & busy_q);
    done_d    = (state_q == ST_FINISH);
    plot_d    = (state_d == ST_DRAW);
    colour_d  = plot_d ? (cur_q[idx_q] ? FG_COLOUR : BG_COLOUR) : colour_q;
  end

  assign plot       = plot_q;
  assign colour     = colour_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_plotter.sv
// Directed plus randomized frames checked pixel-by-pixel against a cell-level reference model.
module tb_frame_plotter;

  logic         clk = 1'b0;
  logic         reset, frame_tick, force_redraw;
  logic [511:0] display;
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot, busy, frame_done, overrun;

  always #5 clk = ~clk;

  frame_plotter dut (
    .clock        (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .display      (display),
    .force_redraw (force_redraw),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int frame_no  = 0;

  typedef struct {
    int px;
    int py;
    int pc;
    int pcyc;
  } pix_t;

  pix_t         exp_q[$];
  logic [511:0] model_prev;
  bit           model_pending;
  int           exp_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_asserts++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Expected pixel stream for a frame; cycle 0 is the tick cycle, each scanned
  // cell costs one cycle and each drawn cell nine more.
  function automatic void build_model(input logic [511:0] disp, input bit full);
    int t;
    int i;
    pix_t p;
    exp_q.delete();
    t = 1;
    for (int cx = 0; cx < 16; cx++) begin
      for (int cy = 0; cy < 32; cy++) begin
        i = 32 * cx + cy;
        if (full || (disp[i] != model_prev[i])) begin
          for (int sy = 0; sy < 3; sy++) begin
            for (int sx = 0; sx < 3; sx++) begin
              p.px   = cx * 3 + sx;
              p.py   = cy * 3 + sy;
              p.pc   = disp[i] ? 0 : 1;
              p.pcyc = t + 1 + sy * 3 + sx;
              exp_q.push_back(p);
            end
          end
          t += 10;
        end else begin
          t += 1;
        end
      end
    end
    exp_done = t + 1;
  endfunction

  task automatic run_frame(input bit force_i, input int retick_at,
                           output int n_plots, output int first_x, output int first_y);
    pix_t p;
    int   cyc;
    bit   done;
    build_model(display, force_i || model_pending);
    frame_tick   = 1'b1;
    force_redraw = force_i;
    @(posedge clk); #1;
    frame_tick   = 1'b0;
    force_redraw = 1'b0;
    cyc     = 1;
    n_plots = 0;
    done    = 1'b0;
    first_x = -1;
    first_y = -1;
    check("busy_after_tick", 32'(busy), 1);
    while (!done && cyc < 8000) begin
      if (plot === 1'b1) begin
        if (n_plots == 0) begin
          first_x = int'(x);
          first_y = int'(y);
        end
        n_plots++;
        if (exp_q.size() == 0) begin
          check("unexpected_plot_cycle", cyc, 0);
        end else begin
          p = exp_q.pop_front();
          check("pix_x", 32'(x), p.px);
          check("pix_y", 32'(y), p.py);
          check("pix_colour", 32'(colour), p.pc);
          check("pix_cycle", cyc, p.pcyc);
        end
      end
      frame_tick = (cyc == retick_at);
      if (frame_done === 1'b1) begin
        done = 1'b1;
        check("frame_done_cycle", cyc, exp_done);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    frame_tick = 1'b0;
    check("frame_done_seen", 32'(done), 1);
    check("missing_plots", exp_q.size(), 0);
    check("busy_at_done", 32'(busy), 0);
    @(posedge clk); #1;
    check("frame_done_single", 32'(frame_done), 0);
    check("plot_after_frame", 32'(plot), 0);
    model_prev    = display;
    model_pending = 1'b0;
    exp_q.delete();
    $display("frame %0d: force=%0d plots=%0d done_cycle=%0d overrun=%0d",
             frame_no, force_i, n_plots, cyc, overrun);
    frame_no++;
  endtask

  initial begin
    int np, fx, fy, bit_i, flips, guard;
    bit saw_plot;

    reset        = 1'b1;
    frame_tick   = 1'b0;
    force_redraw = 1'b0;
    display      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_colour", 32'(colour), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset         = 1'b0;
    model_prev    = '0;
    model_pending = 1'b1;
    @(posedge clk); #1;

    // First frame after reset redraws everything in background colour.
    run_frame(1'b0, -1, np, fx, fy);
    check("full_after_reset_plots", np, 4608);
    check("full_first_x", fx, 0);
    check("full_first_y", fy, 0);

    run_frame(1'b0, -1, np, fx, fy);
    check("unchanged_plots", np, 0);

    display[32*2+5] = 1'b1;
    run_frame(1'b0, -1, np, fx, fy);
    check("set_bit_plots", np, 9);
    check("set_bit_first_x", fx, 6);
    check("set_bit_first_y", fy, 15);

    display[32*2+5] = 1'b0;
    run_frame(1'b0, -1, np, fx, fy);
    check("clear_bit_plots", np, 9);

    // force_redraw alone must not start anything.
    force_redraw = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("no_tick_busy", 32'(busy), 0);
      check("no_tick_plot", 32'(plot), 0);
    end
    force_redraw = 1'b0;

    check("overrun_before", 32'(overrun), 0);
    bit_i = $urandom_range(0, 511);
    display[bit_i] = ~display[bit_i];
    bit_i = $urandom_range(0, 511);
    display[bit_i] = ~display[bit_i];
    run_frame(1'b0, 100, np, fx, fy);
    check("overrun_set", 32'(overrun), 1);

    run_frame(1'b1, -1, np, fx, fy);
    check("force_redraw_plots", np, 4608);

    for (int f = 0; f < 3; f++) begin
      flips = $urandom_range(1, 8);
      for (int k = 0; k < flips; k++) begin
        bit_i = $urandom_range(0, 511);
        display[bit_i] = ~display[bit_i];
      end
      run_frame(1'b0, -1, np, fx, fy);
    end

    for (int w = 0; w < 16; w++) display[w*32 +: 32] = $urandom();
    run_frame(1'b0, -1, np, fx, fy);

    // Abort a frame mid-DRAW with reset.
    display[300] = ~display[300];
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    saw_plot = 1'b0;
    guard    = 0;
    while (!saw_plot && guard < 2000) begin
      if (plot === 1'b1) saw_plot = 1'b1;
      else begin
        @(posedge clk); #1;
        guard++;
      end
    end
    check("reset_test_reached_draw", 32'(saw_plot), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_plot", 32'(plot), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_overrun", 32'(overrun), 0);
    reset         = 1'b0;
    model_prev    = '0;
    model_pending = 1'b1;
    @(posedge clk); #1;
    $display("reset: applied mid-frame after %0d cycles", guard);
    run_frame(1'b0, -1, np, fx, fy);
    check("redraw_after_reset_plots", np, 4608);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
